flip_gather: RTL
================

// Module: flip_gather
// PURPOSE
//  Downstream of flip8. Collects the four per-line flip results (row, column, diagonal,
//  anti-diagonal) for one move, scatters each 8-bit line mask back onto the 64-bit board,
//  ORs them, applies the move and returns the next-turn board pair with a legality flag.
//  Board bit index = row*8+col; pos = row*8+col.
// PARAMETERS
//  SWAP_SIDES  1  1: out_player/out_opponent swapped (side to move next); 0: not swapped
// PORTS
//  clock         in   1   single clock
//  reset         in   1   synchronous, active-high
//  start_valid   in   1   job offer: player/opponent/pos valid
//  start_ready   out  1   high only in IDLE
//  player        in   64  side to move
//  opponent      in   64  other side
//  pos           in   6   move square
//  line_valid    in   1   one line result offered
//  line_ready    out  1   high only in COLLECT
//  line_idx      in   2   0 row, 1 column, 2 diagonal (row-col const), 3 anti-diag (row+col const)
//  flip_upper    in   8   flip8 upper result
//  flip_lower    in   8   flip8 lower result (bit-reversed)
//  out_valid     out  1   result held until out_ready
//  out_ready     in   1   consumer accepts
//  out_player    out  64  next board, side A
//  out_opponent  out  64  next board, side B
//  flip_mask     out  64  squares flipped
//  legal         out  1   move legal
//  err           out  1   sticky protocol/consistency error
// BEHAVIOUR
//  - Reset: state IDLE; start_ready=1, line_ready=0, out_valid=0, all data outputs 0, err=0,
//    line counter 0. Reset mid-job drops the job; no output is produced for it.
//  - FSM IDLE -> COLLECT on start_valid&start_ready (latch player, opponent, pos; clear acc).
//    COLLECT: each line_valid&line_ready accepts one line; counter 0..3 wraps to 0 on the 4th
//    and moves to OUT. OUT: out_valid=1, outputs stable; out_valid&out_ready -> IDLE.
//  - Line L = flip_upper | rev8(flip_lower); bit k maps: row (r,k); col (k,c);
//    diag (k,k+c-r); anti (k,r+c-k). Bits mapping off-board are discarded (masked to 0).
//  - Accumulate acc |= scatter(L) in the accept cycle; outputs register in the cycle of the
//    4th accept; out_valid rises the following cycle. Min latency start accept -> out_valid = 5 cycles.
//  - legal = |acc & ~occupied(pos). occupied(pos) = (player|opponent)[pos].
//  - legal=1: A = player|acc|(1<<pos), B = opponent&~acc. legal=0: A = player, B = opponent,
//    flip_mask = 0. SWAP_SIDES=1: out_player=B, out_opponent=A; else out_player=A, out_opponent=B.
//  - start_valid outside IDLE and line_valid outside COLLECT are ignored (no accept).
//  - out_ready in the same cycle out_valid rises completes the transfer; start_ready is 1 the next cycle.
// CONFIGURATION
//  - GATHER_CHECK_EN defined: line_idx must equal counter, else err<=1 (line still accepted
//    as the counter's index); acc & ~opponent != 0 at OUT entry also sets err. err clears
//    only on reset.
//  - Undefined: line_idx ignored (counter selects mapping), err tied 0.
// TESTING
//  - Opening, player=64'h0000_0008_1000_0000, opponent=64'h0000_0010_0800_0000, pos=19;
//    lines row/col/diag/anti = 0/8'h08/0/0 (col via upper) -> flip_mask=64'h0000_0000_0800_0000,
//    legal=1, out_player=64'h0000_0010_0000_0000, out_opponent=64'h0000_0008_1808_0000.
//  - Same job, all lines 0 -> legal=0, flip_mask=0, out_player=opponent, out_opponent=player.
//  - pos=27 (occupied) with col line 8'h10 -> legal=0, flip_mask=0.
//  - Hold out_ready=0 for 10 cycles -> out_valid stays 1, outputs stable, start_ready=0; then
//    out_ready=1 -> IDLE next cycle.
//  - Assert reset after 2nd line accepted -> next job with all-zero lines gives flip_mask=0,
//    no stale bits.
//  - GATHER_CHECK_EN: line_idx order 0,2,1,3 -> err=1 and stays 1 until reset.

Source files
------------

// File: rtl/flip_gather.sv
// Gathers the four flip8 line results for one move, scatters them onto the board,
// applies the move and returns the next-turn board pair. Optional checks: GATHER_CHECK_EN.
module flip_gather #(
    parameter int SWAP_SIDES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [63:0] player,
    input  logic [63:0] opponent,
    input  logic [5:0]  pos,
    input  logic        line_valid,
    output logic        line_ready,
    input  logic [1:0]  line_idx,
    input  logic [7:0]  flip_upper,
    input  logic [7:0]  flip_lower,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_player,
    output logic [63:0] out_opponent,
    output logic [63:0] flip_mask,
    output logic        legal,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUT     = 2'd2
    } state_t;

    // flip8 reports the lower half scanning away from the move, hence reversed
    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        r = 8'd0;
        for (int k = 0; k < 8; k++) begin
            r[k[2:0]] = b[3'(7 - k)];
        end
        return r;
    endfunction

    // Place line bit k on the board for the line through (r,c); off-board squares drop out
    function automatic logic [63:0] scatter(input logic [1:0] idx, input logic [7:0] line,
                                            input logic [2:0] r, input logic [2:0] c);
        logic [63:0] m;
        int row;
        int col;
        m = 64'd0;
        for (int k = 0; k < 8; k++) begin
            case (idx)
                2'd0:    begin row = int'(r); col = k;                      end
                2'd1:    begin row = k;       col = int'(c);                end
                2'd2:    begin row = k;       col = k + int'(c) - int'(r);  end
                2'd3:    begin row = k;       col = int'(r) + int'(c) - k;  end
                default: begin row = -1;      col = -1;                     end
            endcase
            if (line[k[2:0]] && row >= 0 && row < 8 && col >= 0 && col < 8) begin
                m = m | (64'd1 << (row * 8 + col));
            end else begin
                m = m;
            end
        end
        return m;
    endfunction

    state_t      state_r, state_s;
    logic [63:0] player_r, opponent_r, acc_r;
    logic [5:0]  pos_r;
    logic [1:0]  cnt_r;
    logic        start_ready_r, line_ready_r, out_valid_r, err_r, legal_r;
    logic [63:0] out_player_r, out_opponent_r, flip_mask_r;

    logic        start_acc_s, line_acc_s, last_s, occ_s, legal_s, err_set_s;
    logic [7:0]  line_s;
    logic [63:0] acc_s, a_s, b_s, mask_s;

    assign start_acc_s = start_valid & start_ready_r;
    assign line_acc_s  = line_valid & line_ready_r;
    assign last_s      = line_acc_s & (cnt_r == 2'd3);

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_acc_s) state_s = COLLECT;
                else             state_s = IDLE;
            end
            COLLECT: begin
                if (last_s) state_s = OUT;
                else        state_s = COLLECT;
            end
            OUT: begin
                if (out_valid_r && out_ready) state_s = IDLE;
                else                          state_s = OUT;
            end
            default: state_s = IDLE;
        endcase
    end

    // Scatter the offered line and form the result the move would produce
    always_comb begin
        line_s  = flip_upper | rev8(flip_lower);
        acc_s   = acc_r | scatter(cnt_r, line_s, pos_r[5:3], pos_r[2:0]);
        occ_s   = player_r[pos_r] | opponent_r[pos_r];
        legal_s = (|acc_s) & ~occ_s;
        if (legal_s) begin
            a_s    = player_r | acc_s | (64'd1 << pos_r);
            b_s    = opponent_r & ~acc_s;
            mask_s = acc_s;
        end else begin
            a_s    = player_r;
            b_s    = opponent_r;
            mask_s = 64'd0;
        end
    end

`ifdef GATHER_CHECK_EN
    // Lines must arrive in row/col/diag/anti order and only flip opponent stones
    always_comb begin
        err_set_s = 1'b0;
        if (line_acc_s && (line_idx != cnt_r)) begin
            err_set_s = 1'b1;
        end else if (last_s && (|(acc_s & ~opponent_r))) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = 1'b0;
        end
    end
`else
    logic unused_s;
    assign unused_s  = ^line_idx;
    assign err_set_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Job latch, accumulator, line counter and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            player_r       <= 64'd0;
            opponent_r     <= 64'd0;
            pos_r          <= 6'd0;
            acc_r          <= 64'd0;
            cnt_r          <= 2'd0;
            start_ready_r  <= 1'b1;
            line_ready_r   <= 1'b0;
            out_valid_r    <= 1'b0;
            out_player_r   <= 64'd0;
            out_opponent_r <= 64'd0;
            flip_mask_r    <= 64'd0;
            legal_r        <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            if (start_acc_s) begin
                player_r   <= player;
                opponent_r <= opponent;
                pos_r      <= pos;
                acc_r      <= 64'd0;
                cnt_r      <= 2'd0;
            end else if (line_acc_s) begin
                acc_r <= acc_s;
                cnt_r <= cnt_r + 2'd1;
            end else begin
                acc_r <= acc_r;
                cnt_r <= cnt_r;
            end
            if (last_s) begin
                out_player_r   <= (SWAP_SIDES != 0) ? b_s : a_s;
                out_opponent_r <= (SWAP_SIDES != 0) ? a_s : b_s;
                flip_mask_r    <= mask_s;
                legal_r        <= legal_s;
            end else begin
                out_player_r   <= out_player_r;
                out_opponent_r <= out_opponent_r;
                flip_mask_r    <= flip_mask_r;
                legal_r        <= legal_r;
            end
            start_ready_r <= (state_s == IDLE);
            line_ready_r  <= (state_s == COLLECT);
            out_valid_r   <= (state_s == OUT);
            err_r         <= err_r | err_set_s;
        end
    end

    assign start_ready  = start_ready_r;
    assign line_ready   = line_ready_r;
    assign out_valid    = out_valid_r;
    assign out_player   = out_player_r;
    assign out_opponent = out_opponent_r;
    assign flip_mask    = flip_mask_r;
    assign legal        = legal_r;
    assign err          = err_r;

endmodule
